// File: rtl/player_motion_controller_pkg.sv
// player_pkg: field indices, packed state type, FSM states and image ids shared by the player pipeline.
package player_pkg;
    localparam int PS_IMG      = 0;
    localparam int PS_X        = 1;
    localparam int PS_Y        = 2;
    localparam int PS_W        = 3;
    localparam int PS_H        = 4;
    localparam int COORD_W_DEF = 11;
    typedef logic [0:4][0:COORD_W_DEF-1] player_state_t;
    typedef enum logic {DRIVE, CRASH} ctrl_state_t;
    localparam int IMG_CAR   = 0;
    localparam int IMG_CRASH = 1;
    localparam int IMG_BLINK = 2;
endpackage

// File: rtl/player_motion_controller_axis_integrator.sv
// player_axis_integrator: one-axis velocity step (accelerate/saturate/decay) and position add with range clamp.
module player_axis_integrator #(
    parameter int W    = 11,
    parameter int VW   = 4,
    parameter int LO   = 0,
    parameter int HI   = 100,
    parameter int VMAX = 4
) (
    input  logic        [W-1:0]  i_pos,
    input  logic signed [VW-1:0] i_vel,
    input  logic                 i_inc,
    input  logic                 i_dec,
    input  logic                 i_decay,
    output logic        [W-1:0]  o_pos,
    output logic signed [VW-1:0] o_vel
);
    localparam logic signed [VW-1:0] VMAX_S = VW'(VMAX);
    localparam logic signed [VW-1:0] ONE    = VW'(1);
    localparam logic signed [VW-1:0] ZERO   = '0;
    localparam logic signed [W:0]    LO_S   = (W+1)'(LO);
    localparam logic signed [W:0]    HI_S   = (W+1)'(HI);
    logic signed [VW-1:0] w_vel;
    logic signed [W:0]    w_sum;
    logic                 w_lo, w_hi;
    assign w_vel = i_inc   ? ((i_vel >= VMAX_S) ? VMAX_S : i_vel + ONE)
                 : i_dec   ? ((i_vel <= -VMAX_S) ? -VMAX_S : i_vel - ONE)
                 : i_decay ? ((i_vel > ZERO) ? i_vel - ONE : (i_vel < ZERO) ? i_vel + ONE : i_vel)
                 : i_vel;
    // position is widened by one bit so a leftward step below zero stays negative
    assign w_sum = $signed({1'b0, i_pos}) + (W+1)'(w_vel);
    assign w_lo  = w_sum < LO_S;
    assign w_hi  = w_sum > HI_S;
    assign o_pos = w_lo ? W'(LO) : w_hi ? W'(HI) : w_sum[W-1:0];
    assign o_vel = (w_lo || w_hi) ? ZERO : w_vel;
endmodule

// File: rtl/player_motion_controller.sv
// player_motion_controller: frame-rate player car steering with lateral inertia, road clamp and crash freeze.
// Define PLAYER_CRASH_BLINK_EN to blink img_id 2/0 every 4 frames in CRASH instead of a steady 1.
module player_motion_controller
    import player_pkg::*;
#(
    parameter int  COORD_W      = 11,
    parameter int  X_INIT       = 256,
    parameter int  Y_INIT       = 380,
    parameter int  CAR_W        = 32,
    parameter int  CAR_H        = 36,
    parameter int  MIN_X        = 242,
    parameter int  MAX_X        = 484,
    parameter int  MAX_VX       = 4,
    parameter int  ACCEL_FRAMES = 4,
    parameter int  CRASH_FRAMES = 60,
    localparam int VX_W         = $clog2(MAX_VX + 1) + 1
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_start,
    input  logic                         plus_is_pressed,
    input  logic                         minus_is_pressed,
    input  logic                         collision,
    output logic [0:4][0:COORD_W-1]      new_player_state,
    output logic signed [VX_W-1:0]       vel_x,
    output logic                         crashed
);
    localparam int AW = $clog2(ACCEL_FRAMES) + 1;
    localparam int CW = $clog2(CRASH_FRAMES) + 1;
    localparam logic [AW-1:0] ACC_TOP  = AW'(ACCEL_FRAMES - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CRASH_FRAMES - 1);
`ifdef PLAYER_CRASH_BLINK_EN
    localparam logic [COORD_W-1:0] IMG_ENTRY = COORD_W'(IMG_BLINK);
`else
    localparam logic [COORD_W-1:0] IMG_ENTRY = COORD_W'(IMG_CRASH);
`endif
    ctrl_state_t            r_state;
    logic [COORD_W-1:0]     r_x, r_img;
    logic signed [VX_W-1:0] r_vx;
    logic [AW-1:0]          r_acc;
    logic [CW-1:0]          r_cnt;
    logic                   r_dir, r_hit;
`ifdef PLAYER_CRASH_BLINK_EN
    logic [1:0]             r_blk;
`endif
    logic                   w_one, w_wrap;
    logic [AW-1:0]          w_acc_base, w_acc_next;
    logic [COORD_W-1:0]     w_x;
    logic signed [VX_W-1:0] w_vx;

    assign w_one      = plus_is_pressed ^ minus_is_pressed;
    // a direction reversal restarts the hold count so vx only moves on a full hold period
    assign w_acc_base = (w_one && (plus_is_pressed != r_dir)) ? '0 : r_acc;
    assign w_wrap     = w_one && (w_acc_base == ACC_TOP);
    assign w_acc_next = (!w_one || w_wrap) ? '0 : w_acc_base + 1'b1;

    player_axis_integrator #(
        .W(COORD_W), .VW(VX_W), .LO(MIN_X), .HI(MAX_X - CAR_W), .VMAX(MAX_VX)
    ) u_axis (
        .i_pos(r_x), .i_vel(r_vx),
        .i_inc(w_wrap & plus_is_pressed), .i_dec(w_wrap & minus_is_pressed), .i_decay(!w_one),
        .o_pos(w_x), .o_vel(w_vx)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= DRIVE;
            r_x     <= COORD_W'(X_INIT);
            r_img   <= COORD_W'(IMG_CAR);
            r_vx    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_hit   <= 1'b0;
`ifdef PLAYER_CRASH_BLINK_EN
            r_blk   <= '0;
`endif
        end else begin
            r_hit <= frame_start ? 1'b0 : (r_hit | collision);
            if (frame_start) begin
                if (r_state == CRASH) begin
                    r_vx <= '0;
                    if (r_cnt == '0) begin
                        r_state <= DRIVE;
                        r_acc   <= '0;
                        r_img   <= COORD_W'(IMG_CAR);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
`ifdef PLAYER_CRASH_BLINK_EN
                        r_blk <= r_blk + 2'd1;
                        if (r_blk == 2'd3)
                            r_img <= (r_img == COORD_W'(IMG_BLINK)) ? COORD_W'(IMG_CAR) : COORD_W'(IMG_BLINK);
`endif
                    end
                end else if (r_hit | collision) begin
                    r_state <= CRASH;
                    r_cnt   <= CNT_LOAD;
                    r_vx    <= '0;
                    r_acc   <= '0;
                    r_img   <= IMG_ENTRY;
`ifdef PLAYER_CRASH_BLINK_EN
                    r_blk   <= '0;
`endif
                end else begin
                    r_x   <= w_x;
                    r_vx  <= w_vx;
                    r_acc <= w_acc_next;
                    if (w_one) r_dir <= plus_is_pressed;
                end
            end
        end
    end

    assign new_player_state = {r_img, r_x, COORD_W'(Y_INIT), COORD_W'(CAR_W), COORD_W'(CAR_H)};
    assign vel_x            = r_vx;
    assign crashed          = (r_state == CRASH);
endmodule

// File: tb/tb_player_motion_controller.sv
`timescale 1ns/1ps
// tb_player_motion_controller: directed steering, clamp and crash sequence checked against a frame-level
// reference model through an expected-value queue, plus directed constant checks.
module tb_player_motion_controller;
    import player_pkg::*;
`ifdef PLAYER_CRASH_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    logic clk = 1'b0, resetN = 1'b1, frame_start = 1'b0, plus = 1'b0, minus = 1'b0, collision = 1'b0;
    logic [0:4][0:10] st;
    logic signed [3:0] vel_x;
    logic crashed;
    int n_chk = 0, n_pass = 0;
    typedef struct {int img; int x; int vx; int cr;} exp_t;
    exp_t q[$];
    int m_x, m_vx, m_acc, m_cnt, m_k, m_img;
    bit m_crash, m_hit, m_dir;

    player_motion_controller dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start),
        .plus_is_pressed(plus), .minus_is_pressed(minus), .collision(collision),
        .new_player_state(st), .vel_x(vel_x), .crashed(crashed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_x = 256; m_vx = 0; m_acc = 0; m_cnt = 0; m_k = 0; m_img = 0;
        m_crash = 0; m_hit = 0; m_dir = 0;
    endtask

    task automatic model_step(input bit p, input bit m);
        int nx;
        if (m_crash) begin
            m_vx = 0;
            if (m_cnt == 0) begin
                m_crash = 0; m_acc = 0; m_img = 0;
            end else begin
                m_cnt--; m_k++;
                m_img = BLINK ? (((m_k / 4) % 2 == 0) ? 2 : 0) : 1;
            end
        end else if (m_hit) begin
            m_crash = 1; m_cnt = 59; m_vx = 0; m_acc = 0; m_k = 0; m_img = BLINK ? 2 : 1;
        end else begin
            if (p == m) begin
                m_acc = 0;
                m_vx = (m_vx > 0) ? m_vx - 1 : (m_vx < 0) ? m_vx + 1 : 0;
            end else begin
                if (p != m_dir) m_acc = 0;
                m_dir = p;
                m_acc++;
                if (m_acc == 4) begin
                    m_acc = 0;
                    m_vx += p ? 1 : -1;
                    if (m_vx > 4) m_vx = 4;
                    if (m_vx < -4) m_vx = -4;
                end
            end
            nx = m_x + m_vx;
            if (nx < 242) begin m_x = 242; m_vx = 0; end
            else if (nx > 452) begin m_x = 452; m_vx = 0; end
            else m_x = nx;
        end
        m_hit = 0;
    endtask

    task automatic frame(input bit p, input bit m);
        exp_t e;
        plus = p; minus = m; frame_start = 1'b1;
        model_step(p, m);
        q.push_back('{m_img, m_x, m_vx, int'(m_crash)});
        @(posedge clk); #1 frame_start = 1'b0;
        e = q.pop_front();
        chk("sb_img", st[PS_IMG], e.img);
        chk("sb_x", st[PS_X], e.x);
        chk("sb_vx", vel_x, e.vx);
        chk("sb_crashed", crashed, e.cr);
        @(posedge clk); #1;
    endtask

    task automatic collide();
        collision = 1'b1; m_hit = 1;
        @(posedge clk); #1 collision = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_img"}, st[PS_IMG], 0);
        chk({tag, "_x"}, st[PS_X], 256);
        chk({tag, "_y"}, st[PS_Y], 380);
        chk({tag, "_w"}, st[PS_W], 32);
        chk({tag, "_h"}, st[PS_H], 36);
        chk({tag, "_vx"}, vel_x, 0);
        chk({tag, "_crashed"}, crashed, 0);
    endtask

    initial begin
        model_reset();
        #2 resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset("rst");
        resetN = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 16; i++) begin
            frame(1, 0);
            if (i % 4 == 0) chk("accel_vx", vel_x, i / 4);
        end
        chk("accel_x", st[PS_X], 284);
        for (int i = 0; i < 4; i++) frame(1, 0);
        chk("accel_sat", vel_x, 4);
        for (int i = 1; i <= 4; i++) begin
            frame(0, 0);
            chk("decay_vx", vel_x, 4 - i);
        end
        for (int i = 0; i < 16; i++) frame(1, 0);
        for (int i = 1; i <= 4; i++) begin
            frame(1, 1);
            chk("both_vx", vel_x, 4 - i);
        end
        for (int i = 0; i < 40; i++) begin
            frame(1, 0);
            chk("x_le_max", st[PS_X] <= 452, 1);
        end
        chk("right_x", st[PS_X], 452);
        chk("right_vx", vel_x, 0);
        for (int i = 0; i < 80; i++) begin
            frame(0, 1);
            chk("x_ge_min", st[PS_X] >= 242, 1);
        end
        chk("left_x", st[PS_X], 242);
        chk("left_vx", vel_x, 0);
        frame(0, 0);
        for (int i = 0; i < 8; i++) frame(1, 0);
        chk("pre_crash_vx", vel_x, 2);
        collide();
        frame(1, 0);
        chk("crash_entry", crashed, 1);
        chk("crash_vx", vel_x, 0);
        chk("crash_x", st[PS_X], 248);
        chk("crash_img0", st[PS_IMG], BLINK ? 2 : 1);
        for (int i = 1; i <= 60; i++) begin
            if (i == 30) collide();
            frame(1, 0);
            chk("crash_hold", crashed, i < 60);
            if (i < 8) chk("crash_img", st[PS_IMG], BLINK ? ((i < 4) ? 2 : 0) : 1);
        end
        chk("crash_exit_x", st[PS_X], 248);
        for (int i = 0; i < 6; i++) frame(1, 0);
        chk("post_crash", crashed, 0);
        chk("post_crash_vx", vel_x, 1);
        collide();
        for (int i = 0; i < 4; i++) frame(0, 0);
        chk("crash_again", crashed, 1);
        #3 resetN = 1'b0;
        #1 check_reset("async_rst");
        model_reset();
        @(posedge clk); #1 check_reset("rst_hold");
        resetN = 1'b1;
        @(posedge clk); #1;
        frame(1, 0);
        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
